// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the memory-port arbiter
package mem_arb_pkg;
   localparam int DEF_ADDR_W = 10;
   localparam int DEF_LINE_W = 128;
   localparam int DEF_WORD_W = 32;
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
   typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational 2-way round-robin pick
// Ports: req[1:0] pending requests, last id granted previously,
//        gnt_valid any request pending, gnt_id chosen requester.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt_id
);
   assign gnt_valid = |req;
   // on a tie the requester that did not win last time goes next
   assign gnt_id = &req ? ~last : req[1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between icache (id 0) and dcache (id 1)
// Ports: r0_* icache line-read request/ready, r1_* dcache read/write request/ready,
//        line_out last line read, arb_err timeout completion flag,
//        mem_* memory strobes, latched address/data, returned line and ready.
// Build option: define ARB_TIMEOUT_EN to abort BUSY after TIMEOUT cycles.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int LINE_W  = DEF_LINE_W,
   parameter int WORD_W  = DEF_WORD_W,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_read,
   input  logic [ADDR_W-1:0] r0_addr,
   output logic              r0_ready,
   input  logic              r1_read,
   input  logic              r1_write,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [WORD_W-1:0] r1_wdata,
   output logic              r1_ready,
   output logic [LINE_W-1:0] line_out,
   output logic              arb_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready
);
   state_t            state;
   op_t               op;
   logic              gnt_id;
   logic              last_grant;
   logic              gnt_valid;
   logic              pick_id;
   logic              err_q;
   logic              timeout;
   logic [ADDR_W-1:0] addr_q;
   logic [WORD_W-1:0] wdata_q;

   rr_pick2 u_pick (
      .req       ({r1_read | r1_write, r0_read}),
      .last      (last_grant),
      .gnt_valid (gnt_valid),
      .gnt_id    (pick_id)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt;
   // zero outside BUSY, so the first BUSY cycle sees 0
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= state == BUSY ? cnt + 1'b1 : '0;
   // a mem_ready on the last allowed cycle still completes normally
   assign timeout = state == BUSY && cnt == CNT_W'(TIMEOUT - 1) && !mem_ready;
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         gnt_id     <= 1'b0;
         op         <= OP_READ;
         addr_q     <= '0;
         wdata_q    <= '0;
         line_out   <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (gnt_valid) begin
               state   <= BUSY;
               gnt_id  <= pick_id;
               addr_q  <= pick_id ? r1_addr : r0_addr;
               wdata_q <= r1_wdata;
               // read+write together from the dcache counts as a write
               op      <= pick_id && r1_write ? OP_WRITE : OP_READ;
            end
            BUSY: if (mem_ready || timeout) begin
               state      <= RESP;
               last_grant <= gnt_id;
               err_q      <= timeout;
               if (mem_ready && op == OP_READ) line_out <= mem_rdata;
            end
            default: state <= IDLE;
         endcase
      end

   // strobes decode from state so an async reset drops them at once
   assign mem_read  = state == BUSY && op == OP_READ;
   assign mem_write = state == BUSY && op == OP_WRITE;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign r0_ready  = state == RESP && !gnt_id;
   assign r1_ready  = state == RESP && gnt_id;
   assign arb_err   = state == RESP && err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter
module tb_mem_arbiter;
   logic         clk = 1'b0;
   logic         rst, r0_read, r1_read, r1_write, mem_ready;
   logic [9:0]   r0_addr, r1_addr, mem_addr;
   logic [31:0]  r1_wdata, mem_wdata;
   logic [127:0] mem_rdata, line_out;
   logic         r0_ready, r1_ready, arb_err, mem_read, mem_write;
   int           n_cmp = 0;
   int           n_bad = 0;

   typedef struct {
      logic         id;
      logic         wr;
      logic         rd_too;
      logic [9:0]   addr;
      logic [31:0]  wdata;
      logic [127:0] rdata;
      int           delay;
      logic [127:0] exp_line;
   } vec_t;
   typedef struct {
      logic         id;
      logic [127:0] line;
      logic         err;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   vec_t vecs[5];

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .r0_read(r0_read), .r0_addr(r0_addr), .r0_ready(r0_ready),
      .r1_read(r1_read), .r1_write(r1_write), .r1_addr(r1_addr),
      .r1_wdata(r1_wdata), .r1_ready(r1_ready),
      .line_out(line_out), .arb_err(arb_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // scoreboard consumer: every ready pulse must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && (r0_ready || r1_ready)) begin
         if (sb.size() == 0) chk("unexpected_ready", sb.size(), 1);
         else begin
            m_e = sb.pop_front();
            chk("mon_both_ready", r0_ready & r1_ready, 0);
            chk("mon_id", r1_ready, m_e.id);
            chk("mon_line", line_out, m_e.line);
            chk("mon_err", arb_err, m_e.err);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   task automatic clear_req();
      r0_read = 0; r1_read = 0; r1_write = 0;
   endtask

   task automatic do_reset();
      rst = 1; clear_req(); mem_ready = 0; mem_rdata = '0;
      r0_addr = '0; r1_addr = '0; r1_wdata = '0;
      @(posedge clk); #1;
      rst = 0;
   endtask

   task automatic wait_strobe(output int n);
      n = 0;
      while (!(mem_read || mem_write) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("strobe_seen", mem_read || mem_write, 1);
   endtask

   // last BUSY cycle: answer with mem_ready, then sit in RESP
   task automatic complete(input logic id, input logic [127:0] rdata, input logic [127:0] exp_line);
      sb.push_back('{id, exp_line, 1'b0});
      mem_ready = 1; mem_rdata = rdata;
      @(posedge clk); #1;
      mem_ready = 0;
      chk("ready_pulse", {r1_ready, r0_ready}, id ? 2'b10 : 2'b01);
   endtask

   task automatic run_vec(input vec_t v);
      int n, good;
      r0_read = !v.id; r1_read = v.id & (!v.wr | v.rd_too); r1_write = v.id & v.wr;
      r0_addr = v.addr; r1_addr = v.addr; r1_wdata = v.wdata;
      wait_strobe(n);
      good = 0;
      for (int k = 0; k < v.delay; k++) begin
         if (mem_read == !v.wr && mem_write == v.wr && mem_addr == v.addr &&
             (!v.wr || mem_wdata == v.wdata)) good++;
         if (k < v.delay - 1) begin
            @(posedge clk); #1;
         end
      end
      chk("busy_cycles", good, v.delay);
      complete(v.id, v.rdata, v.exp_line);
      chk("strobe_in_resp", {mem_read, mem_write}, 2'b00);
      clear_req();
      @(posedge clk); #1;
      chk("ready_drop", {r1_ready, r0_ready}, 2'b00);
   endtask

   initial begin
      int n;
      logic [127:0] l0, l2, lf, ln;
      l0 = 128'hDEADBEEF_00000000_00000000_00000001;
      l2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
      lf = '1;
      vecs[0] = '{1'b0, 1'b0, 1'b0, 10'h08C, 32'h0, l0, 4, l0};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 10'h3FC, 32'hA5A5A5A5, 128'h5555, 2, l0};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 10'h123, 32'h0, l2, 1, l2};
      vecs[3] = '{1'b0, 1'b0, 1'b0, 10'h000, 32'h0, lf, 3, lf};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 10'h001, 32'h12345678, 128'h0, 1, lf};

      rst = 1; clear_req(); mem_ready = 0; mem_rdata = '0;
      r0_addr = '0; r1_addr = '0; r1_wdata = '0;
      #2;
      chk("rst_line", line_out, 0);
      chk("rst_ready", {r1_ready, r0_ready}, 0);
      chk("rst_strobe", {mem_read, mem_write}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_err", arb_err, 0);
      do_reset();

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // stray mem_ready while idle
      mem_ready = 1; mem_rdata = 128'h77;
      @(posedge clk); #1;
      mem_ready = 0;
      chk("stray_line", line_out, lf);
      chk("stray_ready", {r1_ready, r0_ready}, 0);
      chk("stray_strobe", {mem_read, mem_write}, 0);
      @(posedge clk); #1;
      chk("stray_ready2", {r1_ready, r0_ready}, 0);
      chk("stray_strobe2", {mem_read, mem_write}, 0);

      // tie after reset: grants alternate starting with requester 0
      do_reset();
      r0_read = 1; r0_addr = 10'h100; r1_read = 1; r1_addr = 10'h200;
      for (int k = 0; k < 4; k++) begin
         ln = {96'hC0DE, 32'(k + 1)};
         wait_strobe(n);
         chk("tie_gap", n, k == 0 ? 1 : 2);
         chk("tie_addr", mem_addr, k % 2 ? 10'h200 : 10'h100);
         complete(k % 2 == 1, ln, ln);
      end
      clear_req();
      @(posedge clk); #1;

      // reset mid-op, only requester 1 pending afterwards
      do_reset();
      r0_read = 1; r0_addr = 10'h0AA;
      wait_strobe(n);
      r1_read = 1; r1_addr = 10'h155;
      #2 rst = 1;
      #1;
      chk("rstA_strobe", mem_read, 0);
      chk("rstA_ready", {r1_ready, r0_ready}, 0);
      r0_read = 0;
      @(posedge clk); #1;
      rst = 0;
      wait_strobe(n);
      chk("rstA_grant", mem_addr, 10'h155);
      complete(1'b1, 128'hA1, 128'hA1);
      clear_req();
      @(posedge clk); #1;

      // reset mid-op with both pending: requester 0 wins the reset tie
      r1_read = 1; r1_addr = 10'h155;
      wait_strobe(n);
      r0_read = 1; r0_addr = 10'h0AA;
      #2 rst = 1;
      #1;
      chk("rstB_strobe", mem_read, 0);
      @(posedge clk); #1;
      rst = 0;
      wait_strobe(n);
      chk("rstB_grant", mem_addr, 10'h0AA);
      complete(1'b0, 128'hB2, 128'hB2);
      clear_req();
      @(posedge clk); #1;

`ifdef ARB_TIMEOUT_EN
      do_reset();
      r1_read = 1; r1_addr = 10'h2C0;
      sb.push_back('{1'b1, 128'h0, 1'b1});
      wait_strobe(n);
      n = 1;
      while (mem_read && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      n--;
      chk("to_busy_cycles", n, 16);
      chk("to_ready", r1_ready, 1);
      chk("to_err", arb_err, 1);
      clear_req();
      @(posedge clk); #1;
      chk("to_err_drop", arb_err, 0);
      run_vec('{1'b1, 1'b0, 1'b0, 10'h2C4, 32'h0, l2, 2, l2});
`endif

      repeat (2) @(posedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
